// File: rtl/dmem_responder.sv
// dmem_responder: word-organised data memory on the proc2Dmem/Dmem2proc bus with fixed-latency, in-order tagged load returns.
// Build macro DMEM_ALIGN_CHECK_EN makes the responder reject misaligned HALF/WORD requests.
module dmem_responder #(
    parameter int MEM_WORDS = 256,
    parameter int LATENCY   = 4,
    parameter int DEPTH     = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  proc2Dmem_command,
    input  logic [1:0]  proc2Dmem_size,
    input  logic [31:0] proc2Dmem_addr,
    input  logic [31:0] proc2Dmem_data,
    output logic [3:0]  Dmem2proc_response,
    output logic [31:0] Dmem2proc_data,
    output logic [3:0]  Dmem2proc_tag
);

    localparam int IDX_W   = $clog2(MEM_WORDS);
    localparam int ADDR_HI = IDX_W + 2;
    localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W   = $clog2(DEPTH + 1);
    localparam int LAT_W   = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    localparam logic [1:0] BUS_LOAD  = 2'd1;
    localparam logic [1:0] BUS_STORE = 2'd2;
    localparam logic [1:0] SZ_BYTE   = 2'd0;
    localparam logic [1:0] SZ_HALF   = 2'd1;
    localparam logic [1:0] SZ_WORD   = 2'd2;

    logic [31:0]      r_mem [MEM_WORDS];

    logic [3:0]       r_fifo_tag  [DEPTH];
    logic [31:0]      r_fifo_data [DEPTH];
    logic [LAT_W-1:0] r_fifo_cnt  [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic [3:0]       r_tag_ctr;
    logic [3:0]       r_tag_out;
    logic [31:0]      r_data_out;

    logic             w_is_load;
    logic             w_is_store;
    logic             w_in_range;
    logic             w_aligned;
    logic             w_has_room;
    logic             w_accept;
    logic             w_push;
    logic             w_pop;
    logic [IDX_W-1:0] w_idx;
    logic [CNT_W:0]   w_occupancy;
    logic [31:0]      w_rd_word;
    logic [31:0]      w_wr_word;

    assign w_is_load  = (proc2Dmem_command == BUS_LOAD);
    assign w_is_store = (proc2Dmem_command == BUS_STORE);
    assign w_in_range = (proc2Dmem_addr[31:ADDR_HI] == '0);
    assign w_idx      = proc2Dmem_addr[ADDR_HI-1:2];
    assign w_rd_word  = r_mem[w_idx];

`ifdef DMEM_ALIGN_CHECK_EN
    always_comb begin
        w_aligned = 1'b1;
        if ((proc2Dmem_size == SZ_HALF) && proc2Dmem_addr[0])
            w_aligned = 1'b0;
        if ((proc2Dmem_size == SZ_WORD) && (proc2Dmem_addr[1:0] != 2'b00))
            w_aligned = 1'b0;
    end
`else
    assign w_aligned = 1'b1;
`endif

    // The load being presented on the return port still holds its slot this cycle.
    assign w_occupancy = {1'b0, r_count} + {{CNT_W{1'b0}}, (r_tag_out != 4'd0)};
    assign w_has_room  = (w_occupancy < (CNT_W + 1)'(DEPTH));

    assign w_accept = reset && w_in_range && w_aligned
                      && (w_is_store || (w_is_load && w_has_room));

    assign Dmem2proc_response = w_accept ? r_tag_ctr : 4'd0;

    // LATENCY==1 bypasses the FIFO and registers the read word at the accept edge.
    assign w_push = w_accept && w_is_load && (LATENCY > 1);
    assign w_pop  = (r_count != '0) && (r_fifo_cnt[r_rd_ptr] == LAT_W'(1));

    always_comb begin
        w_wr_word = w_rd_word;
        case (proc2Dmem_size)
            SZ_BYTE: w_wr_word[{proc2Dmem_addr[1:0], 3'b000} +: 8]  = proc2Dmem_data[7:0];
            SZ_HALF: w_wr_word[{proc2Dmem_addr[1], 4'b0000} +: 16] = proc2Dmem_data[15:0];
            SZ_WORD: w_wr_word = proc2Dmem_data;
            default: w_wr_word = proc2Dmem_data;
        endcase
    end

    always_ff @(posedge clock) begin
        if (w_accept && w_is_store)
            r_mem[w_idx] <= w_wr_word;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_tag_ctr <= 4'd1;
        end else if (w_accept) begin
            r_tag_ctr <= (r_tag_ctr == 4'd15) ? 4'd1 : r_tag_ctr + 4'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_fifo_tag[r_wr_ptr]  <= r_tag_ctr;
            r_fifo_data[r_wr_ptr] <= w_rd_word;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++)
                r_fifo_cnt[i] <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (r_fifo_cnt[i] != '0)
                    r_fifo_cnt[i] <= r_fifo_cnt[i] - LAT_W'(1);
            end
            if (w_push) begin
                r_fifo_cnt[r_wr_ptr] <= LAT_W'(LATENCY - 1);
                r_wr_ptr <= (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
            end
            if (w_pop)
                r_rd_ptr <= (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Return port: tag is a one-cycle pulse, data holds between returns.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_tag_out  <= 4'd0;
            r_data_out <= 32'd0;
        end else if ((LATENCY == 1) && w_accept && w_is_load) begin
            r_tag_out  <= r_tag_ctr;
            r_data_out <= w_rd_word;
        end else if (w_pop) begin
            r_tag_out  <= r_fifo_tag[r_rd_ptr];
            r_data_out <= r_fifo_data[r_rd_ptr];
        end else begin
            r_tag_out  <= 4'd0;
        end
    end

    assign Dmem2proc_tag  = r_tag_out;
    assign Dmem2proc_data = r_data_out;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: accept tags are checked inline, load returns through a cycle-stamped scoreboard.
module tb_dmem_responder;

    localparam int LAT = 4;

    localparam logic [1:0] C_NONE  = 2'd0;
    localparam logic [1:0] C_LOAD  = 2'd1;
    localparam logic [1:0] C_STORE = 2'd2;
    localparam logic [1:0] S_BYTE  = 2'd0;
    localparam logic [1:0] S_HALF  = 2'd1;
    localparam logic [1:0] S_WORD  = 2'd2;

    logic        clock;
    logic        reset;
    logic [1:0]  proc2Dmem_command;
    logic [1:0]  proc2Dmem_size;
    logic [31:0] proc2Dmem_addr;
    logic [31:0] proc2Dmem_data;
    logic [3:0]  Dmem2proc_response;
    logic [31:0] Dmem2proc_data;
    logic [3:0]  Dmem2proc_tag;

    typedef struct {
        int          cyc;
        logic [3:0]  tag;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   cyc;
    int   total;
    int   bad;
    bit   mon_en;

    dmem_responder #(.MEM_WORDS(256), .LATENCY(LAT), .DEPTH(4)) dut (
        .clock              (clock),
        .reset              (reset),
        .proc2Dmem_command  (proc2Dmem_command),
        .proc2Dmem_size     (proc2Dmem_size),
        .proc2Dmem_addr     (proc2Dmem_addr),
        .proc2Dmem_data     (proc2Dmem_data),
        .Dmem2proc_response (Dmem2proc_response),
        .Dmem2proc_data     (Dmem2proc_data),
        .Dmem2proc_tag      (Dmem2proc_tag)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    // Return-port monitor: every cycle either the due entry or tag 0.
    always @(negedge clock) begin
        if (mon_en) begin
            if (exp_q.size() != 0 && exp_q[0].cyc == cyc) begin
                total++;
                assert (Dmem2proc_tag === exp_q[0].tag) else begin
                    bad++;
                    $error("FAIL ret_tag cyc=%0d: observed=%0h expected=%0h", cyc, Dmem2proc_tag, exp_q[0].tag);
                end
                total++;
                assert (Dmem2proc_data === exp_q[0].data) else begin
                    bad++;
                    $error("FAIL ret_data cyc=%0d: observed=%08h expected=%08h", cyc, Dmem2proc_data, exp_q[0].data);
                end
                void'(exp_q.pop_front());
            end else begin
                total++;
                assert (Dmem2proc_tag === 4'd0) else begin
                    bad++;
                    $error("FAIL idle_tag cyc=%0d: observed=%0h expected=0", cyc, Dmem2proc_tag);
                end
            end
        end
    end

    task automatic do_req(input logic [1:0] cmd, input logic [1:0] sz, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] exp_resp,
                          input logic [31:0] exp_data, input string name);
        proc2Dmem_command = cmd;
        proc2Dmem_size    = sz;
        proc2Dmem_addr    = addr;
        proc2Dmem_data    = wdata;
        @(negedge clock);
        total++;
        assert (Dmem2proc_response === exp_resp) else begin
            bad++;
            $error("FAIL resp_%s: observed=%0h expected=%0h", name, Dmem2proc_response, exp_resp);
        end
        if (cmd == C_LOAD && exp_resp != 4'd0)
            exp_q.push_back('{cyc + LAT, exp_resp, exp_data});
        @(posedge clock);
        #1;
        proc2Dmem_command = C_NONE;
    endtask

    task automatic idle(input int n);
        proc2Dmem_command = C_NONE;
        for (int k = 0; k < n; k++) begin
            @(negedge clock);
            total++;
            assert (Dmem2proc_response === 4'd0) else begin
                bad++;
                $error("FAIL idle_resp: observed=%0h expected=0", Dmem2proc_response);
            end
            @(posedge clock);
            #1;
        end
    endtask

    // One-cycle reset with a LOAD held on the bus; pending returns are abandoned.
    task automatic pulse_reset();
        reset = 1'b0;
        exp_q.delete();
        proc2Dmem_command = C_LOAD;
        proc2Dmem_size    = S_WORD;
        proc2Dmem_addr    = 32'h10;
        @(negedge clock);
        total++;
        assert (Dmem2proc_response === 4'd0) else begin
            bad++;
            $error("FAIL resp_in_reset: observed=%0h expected=0", Dmem2proc_response);
        end
        @(posedge clock);
        #1;
        reset = 1'b1;
        proc2Dmem_command = C_NONE;
    endtask

    initial begin
        cyc = 0;
        total = 0;
        bad = 0;
        mon_en = 1'b0;
        reset = 1'b0;
        proc2Dmem_command = C_LOAD;
        proc2Dmem_size    = S_WORD;
        proc2Dmem_addr    = 32'h10;
        proc2Dmem_data    = 32'h0;

        // Reset state
        repeat (2) @(posedge clock);
        @(negedge clock);
        total++;
        assert (Dmem2proc_response === 4'd0) else begin
            bad++; $error("FAIL rst_resp: observed=%0h expected=0", Dmem2proc_response);
        end
        total++;
        assert (Dmem2proc_tag === 4'd0) else begin
            bad++; $error("FAIL rst_tag: observed=%0h expected=0", Dmem2proc_tag);
        end
        total++;
        assert (Dmem2proc_data === 32'd0) else begin
            bad++; $error("FAIL rst_data: observed=%08h expected=0", Dmem2proc_data);
        end
        @(posedge clock);
        #1;
        reset = 1'b1;
        proc2Dmem_command = C_NONE;
        mon_en = 1'b1;

        // Store word, load it back, data holds after the tag pulse
        do_req(C_STORE, S_WORD, 32'h10, 32'hDEADBEEF, 4'd1, 32'h0, "st_word");
        do_req(C_LOAD,  S_WORD, 32'h10, 32'h0,        4'd2, 32'hDEADBEEF, "ld_word");
        idle(4);
        @(negedge clock);
        total++;
        assert (Dmem2proc_data === 32'hDEADBEEF) else begin
            bad++; $error("FAIL data_hold: observed=%08h expected=deadbeef", Dmem2proc_data);
        end
        @(posedge clock);
        #1;

        // Byte and half-word lane merges
        do_req(C_STORE, S_BYTE, 32'h11, 32'h000000AB, 4'd3, 32'h0, "st_byte");
        do_req(C_LOAD,  S_WORD, 32'h10, 32'h0,        4'd4, 32'hDEADABEF, "ld_after_byte");
        do_req(C_STORE, S_HALF, 32'h12, 32'h00001234, 4'd5, 32'h0, "st_half");
        do_req(C_LOAD,  S_WORD, 32'h10, 32'h0,        4'd6, 32'h1234ABEF, "ld_after_half");
        idle(LAT + 1);

        // FIFO full: fifth load collides with the first return and is refused
        pulse_reset();
        do_req(C_LOAD, S_WORD, 32'h10, 32'h0, 4'd1, 32'h1234ABEF, "full_ld1");
        do_req(C_LOAD, S_WORD, 32'h10, 32'h0, 4'd2, 32'h1234ABEF, "full_ld2");
        do_req(C_LOAD, S_WORD, 32'h10, 32'h0, 4'd3, 32'h1234ABEF, "full_ld3");
        do_req(C_LOAD, S_WORD, 32'h10, 32'h0, 4'd4, 32'h1234ABEF, "full_ld4");
        do_req(C_LOAD, S_WORD, 32'h10, 32'h0, 4'd0, 32'h0,        "full_ld5");
        do_req(C_LOAD, S_WORD, 32'h10, 32'h0, 4'd5, 32'h1234ABEF, "after_full");
        idle(LAT + 2);

        // Tag wrap 15 -> 1, out-of-range and command 3 rejected without advancing
        pulse_reset();
        for (int i = 0; i < 16; i++)
            do_req(C_STORE, S_WORD, 32'h40 + 32'(4 * i), 32'(i),
                   (i < 15) ? 4'(i + 1) : 4'd1, 32'h0, "wrap_st");
        do_req(C_LOAD,  S_WORD, 32'h400, 32'h0,        4'd0, 32'h0, "ld_oor");
        do_req(C_STORE, S_WORD, 32'h400, 32'h55555555, 4'd0, 32'h0, "st_oor");
        do_req(2'd3,    S_WORD, 32'h10,  32'h0,        4'd0, 32'h0, "cmd3");
        do_req(C_LOAD,  S_WORD, 32'h44,  32'h0,        4'd2, 32'h1, "ld_after_rej");
        do_req(C_LOAD,  S_WORD, 32'h40,  32'h0,        4'd3, 32'h0, "ld_word0_intact");
        idle(LAT + 1);

        // Reset with loads in flight: no returns afterwards, memory survives
        do_req(C_LOAD, S_WORD, 32'h10, 32'h0, 4'd4, 32'h1234ABEF, "fly_ld1");
        do_req(C_LOAD, S_WORD, 32'h44, 32'h0, 4'd5, 32'h1,        "fly_ld2");
        pulse_reset();
        idle(LAT + 2);
        do_req(C_LOAD, S_WORD, 32'h10, 32'h0, 4'd1, 32'h1234ABEF, "ld_post_rst");
        idle(LAT + 1);

        // Misaligned half-word load
`ifdef DMEM_ALIGN_CHECK_EN
        do_req(C_LOAD, S_HALF, 32'h11, 32'h0, 4'd0, 32'h0, "ld_half_misal");
        do_req(C_LOAD, S_WORD, 32'h12, 32'h0, 4'd0, 32'h0, "ld_word_misal");
        do_req(C_LOAD, S_HALF, 32'h12, 32'h0, 4'd2, 32'h1234ABEF, "ld_half_al");
`else
        do_req(C_LOAD, S_HALF, 32'h11, 32'h0, 4'd2, 32'h1234ABEF, "ld_half_misal");
        do_req(C_LOAD, S_WORD, 32'h12, 32'h0, 4'd3, 32'h1234ABEF, "ld_word_misal");
`endif
        idle(LAT + 2);

        total++;
        assert (exp_q.size() == 0) else begin
            bad++; $error("FAIL sb_drain: observed=%0d expected=0", exp_q.size());
        end
        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
